aes_axis_in_packer: RTL and testbench

- Upstream neighbour of the AES controller.
- Accepts a 32-bit AXI-Stream request packet. The first beat is the command word; the remaining beats are key, IV (CBC only) and data.
- Packs each group of 4 beats into one 128-bit word and writes it into the input block RAM at consecutive addresses starting at 0.
- Publishes the command and the 128-bit word count, pulses the controller's enable, then stalls the stream until the controller reports completion.

---
 rtl/aes_axis_in_packer.sv | 213 +++++++++++++++++++++
 tb/tb_aes_axis_in_packer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_axis_in_packer.sv
// aes_axis_in_packer: packs a 32-bit AXI-Stream request packet into 128-bit words
// for the AES input block RAM, then starts the controller and stalls until it is done.
// Optional statistics counters are enabled with the AES_PACKER_STATS_EN macro.
// in_fifo_blk_cnt carries one extra bit so that a completely full RAM (2^ADDR words)
// is reported as its true count instead of wrapping to zero.
module aes_axis_in_packer #(
    parameter int IN_FIFO_ADDR_WIDTH = 9,
    parameter int IN_FIFO_DATA_WIDTH = 128
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [31:0]                   s_axis_tdata,
    input  logic                          s_axis_tvalid,
    input  logic                          s_axis_tlast,
    output logic                          s_axis_tready,
    output logic [0:31]                   aes_cmd,
    output logic                          in_fifo_w_e,
    output logic [IN_FIFO_ADDR_WIDTH-1:0] in_fifo_addr,
    output logic [0:IN_FIFO_DATA_WIDTH-1] in_fifo_data,
    output logic [IN_FIFO_ADDR_WIDTH:0]   in_fifo_blk_cnt,
    output logic                          ctrl_en,
    input  logic                          ctrl_done,
`ifdef AES_PACKER_STATS_EN
    output logic [31:0]                   pkt_cnt,
    output logic [15:0]                   err_cnt,
`endif
    output logic                          err
);

    localparam int AW = IN_FIFO_ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, RECV, START, WAIT_DONE} state_t;

    state_t                          state_q, state_d;
    logic                            tready_q, tready_d;
    logic [0:31]                     cmd_q, cmd_d;
    logic                            err_q, err_d;
    logic                            w_e_q, w_e_d;
    logic [AW-1:0]                   addr_q, addr_d;
    logic [0:IN_FIFO_DATA_WIDTH-1]   data_q, data_d;
    logic [AW-1:0]                   wr_addr_q, wr_addr_d;
    logic                            full_q, full_d;
    logic [AW:0]                     blk_cnt_q, blk_cnt_d;
    logic [1:0]                      beat_idx_q, beat_idx_d;
    logic [31:0]                     lanes_q [4];
    logic [31:0]                     lanes_d [4];
    logic                            ctrl_en_q, ctrl_en_d;

    logic                            accept;
    logic                            set_err;
    logic                            err_base;
    logic [0:IN_FIFO_DATA_WIDTH-1]   word;

    // Next-state, packing and write-port logic for the packet FSM
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        w_e_d      = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        wr_addr_d  = wr_addr_q;
        full_d     = full_q;
        blk_cnt_d  = blk_cnt_q;
        beat_idx_d = beat_idx_q;
        lanes_d    = lanes_q;
        ctrl_en_d  = 1'b0;
        set_err    = 1'b0;
        err_base   = err_q;
        accept     = s_axis_tvalid && tready_q;

        word = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < int'(beat_idx_q)) begin
                word[32*i +: 32] = lanes_q[i];
            end else if (i == int'(beat_idx_q)) begin
                word[32*i +: 32] = s_axis_tdata;
            end
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    cmd_d      = s_axis_tdata;
                    err_base   = 1'b0;
                    wr_addr_d  = '0;
                    beat_idx_d = '0;
                    blk_cnt_d  = '0;
                    full_d     = 1'b0;
                    if (s_axis_tlast) begin
                        set_err = 1'b1;
                    end else begin
                        state_d = RECV;
                    end
                end
            end
            RECV: begin
                if (accept) begin
                    lanes_d[beat_idx_q] = s_axis_tdata;
                    if (beat_idx_q == 2'd3 || s_axis_tlast) begin
                        beat_idx_d = '0;
                        if (!full_q) begin
                            w_e_d     = 1'b1;
                            addr_d    = wr_addr_q;
                            data_d    = word;
                            blk_cnt_d = blk_cnt_q + 1'b1;
                            if (wr_addr_q == '1) begin
                                full_d = 1'b1;
                            end else begin
                                wr_addr_d = wr_addr_q + 1'b1;
                            end
                        end else begin
                            set_err = 1'b1;
                        end
                    end else begin
                        beat_idx_d = beat_idx_q + 1'b1;
                    end
                    if (s_axis_tlast) begin
                        if (beat_idx_q != 2'd3) begin
                            set_err = 1'b1;
                        end
                        state_d = START;
                    end
                end
            end
            START: begin
                if (blk_cnt_q[AW:1] == '0) begin
                    set_err = 1'b1;
                    state_d = IDLE;
                end else begin
                    ctrl_en_d = 1'b1;
                    state_d   = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (ctrl_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        err_d    = err_base | set_err;
        tready_d = (state_d == IDLE) || (state_d == RECV);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            tready_q   <= 1'b0;
            cmd_q      <= '0;
            err_q      <= 1'b0;
            w_e_q      <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            wr_addr_q  <= '0;
            full_q     <= 1'b0;
            blk_cnt_q  <= '0;
            beat_idx_q <= '0;
            lanes_q    <= '{default: '0};
            ctrl_en_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tready_q   <= tready_d;
            cmd_q      <= cmd_d;
            err_q      <= err_d;
            w_e_q      <= w_e_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wr_addr_q  <= wr_addr_d;
            full_q     <= full_d;
            blk_cnt_q  <= blk_cnt_d;
            beat_idx_q <= beat_idx_d;
            lanes_q    <= lanes_d;
            ctrl_en_q  <= ctrl_en_d;
        end
    end

    assign s_axis_tready   = tready_q;
    assign aes_cmd         = cmd_q;
    assign in_fifo_w_e     = w_e_q;
    assign in_fifo_addr    = addr_q;
    assign in_fifo_data    = data_q;
    assign in_fifo_blk_cnt = blk_cnt_q;
    assign ctrl_en         = ctrl_en_q;
    assign err             = err_q;

`ifdef AES_PACKER_STATS_EN
    logic [31:0] pkt_cnt_q, pkt_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    // Count started packets and packets that newly raised the error flag
    always_comb begin
        pkt_cnt_d = pkt_cnt_q + 32'(ctrl_en_d);
        err_cnt_d = err_cnt_q + 16'(set_err && !err_base);
    end

    // Statistics registers, wrapping silently
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign pkt_cnt = pkt_cnt_q;
    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_aes_axis_in_packer.sv
// Testbench for aes_axis_in_packer: table vectors, randomized packets against a
// packet-level reference model, and hand sequences for latency and mid-packet reset.
module tb_aes_axis_in_packer;

    localparam int AW  = 3;
    localparam int CAP = 8;
    localparam logic [31:0] ECB_ENCRYPT_128 = 32'h0000_0011;
    localparam logic [31:0] CBC_DECRYPT_128 = 32'h0000_0122;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tready;
    logic [0:31]   aes_cmd;
    logic          in_fifo_w_e;
    logic [AW-1:0] in_fifo_addr;
    logic [0:127]  in_fifo_data;
    logic [AW:0]   in_fifo_blk_cnt;
    logic          ctrl_en;
    logic          ctrl_done = 1'b0;
    logic          err;
`ifdef AES_PACKER_STATS_EN
    logic [31:0]   pkt_cnt;
    logic [15:0]   err_cnt;
    int            exp_pkts = 0;
`endif

    int compared = 0;
    int mismatched = 0;

    logic [AW-1:0] wr_addrs [$];
    logic [127:0]  wr_datas [$];
    int            ctrl_en_seen = 0;
    int            beats_in_stall = 0;
    bit            in_stall = 1'b0;

    aes_axis_in_packer #(
        .IN_FIFO_ADDR_WIDTH(AW),
        .IN_FIFO_DATA_WIDTH(128)
    ) dut (
        .clk(clk),
        .reset(reset),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .aes_cmd(aes_cmd),
        .in_fifo_w_e(in_fifo_w_e),
        .in_fifo_addr(in_fifo_addr),
        .in_fifo_data(in_fifo_data),
        .in_fifo_blk_cnt(in_fifo_blk_cnt),
        .ctrl_en(ctrl_en),
        .ctrl_done(ctrl_done),
`ifdef AES_PACKER_STATS_EN
        .pkt_cnt(pkt_cnt),
        .err_cnt(err_cnt),
`endif
        .err(err)
    );

    always #5 clk = ~clk;

    // Passive monitor: logs RAM writes, start pulses and beats taken while stalled
    always @(negedge clk) begin
        if (!reset) begin
            if (in_fifo_w_e) begin
                wr_addrs.push_back(in_fifo_addr);
                wr_datas.push_back(in_fifo_data);
            end
            if (ctrl_en) ctrl_en_seen++;
            if (in_stall && s_axis_tvalid && s_axis_tready) beats_in_stall++;
        end
    end

    typedef struct {
        string       name;
        logic [31:0] cmd;
        int          nbeats;
        int          gap_pct;
        int          done_delay;
        bit          fixed_data;
        int          exp_blk;
        bit          exp_err;
        bit          exp_start;
    } vec_t;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] packWord(input logic [31:0] beats [$], input int w);
        logic [127:0] r;
        r = '0;
        for (int l = 0; l < 4; l++) begin
            if (4 * w + l < beats.size()) r[127 - 32 * l -: 32] = beats[4 * w + l];
        end
        return r;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sendBeat(input logic [31:0] d, input logic last);
        int  guard;
        bit  ok;
        ok = 1'b0;
        guard = 0;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        while (!ok && guard < 200) begin
            @(negedge clk);
            ok = s_axis_tready;
            cycle();
            guard++;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        if (!ok) checkOutput("beat accept timeout", 128'(ok), 128'(1));
    endtask

    task automatic applyStimulus(input string tag, input logic [31:0] cmd, input logic [31:0] beats [$],
                                 input int gap_pct, input int done_delay,
                                 input int exp_blk, input bit exp_err, input bit exp_start);
        int n;
        int guard;
        n = beats.size();
        wr_addrs.delete();
        wr_datas.delete();
        ctrl_en_seen = 0;
        beats_in_stall = 0;
        ctrl_done = 1'b1;
        cycle();
        ctrl_done = 1'b0;
        sendBeat(cmd, n == 0);
        for (int j = 0; j < n; j++) begin
            if ($urandom_range(99) < gap_pct) begin
                repeat ($urandom_range(1, 3)) cycle();
            end
            sendBeat(beats[j], j == n - 1);
        end
        if (exp_start) begin
            in_stall = 1'b1;
            s_axis_tvalid = 1'b1;
            s_axis_tdata = 32'hdead_beef;
            s_axis_tlast = 1'b1;
            guard = 0;
            while (ctrl_en_seen == 0 && guard < 20) begin
                cycle();
                guard++;
            end
            for (int k = 0; k < done_delay; k++) cycle();
            checkOutput({tag, " ctrl_en pulses"}, 128'(ctrl_en_seen), 128'(1));
            checkOutput({tag, " tready stalled"}, 128'(s_axis_tready), 128'(0));
            checkOutput({tag, " beats taken in stall"}, 128'(beats_in_stall), 128'(0));
            ctrl_done = 1'b1;
            s_axis_tvalid = 1'b0;
            s_axis_tlast = 1'b0;
            in_stall = 1'b0;
            cycle();
            ctrl_done = 1'b0;
            checkOutput({tag, " tready after done"}, 128'(s_axis_tready), 128'(1));
`ifdef AES_PACKER_STATS_EN
            exp_pkts++;
`endif
        end else begin
            for (int k = 0; k < 6; k++) cycle();
            checkOutput({tag, " no ctrl_en"}, 128'(ctrl_en_seen), 128'(0));
            checkOutput({tag, " tready idle"}, 128'(s_axis_tready), 128'(1));
        end
        checkOutput({tag, " blk_cnt"}, 128'(in_fifo_blk_cnt), 128'(exp_blk));
        checkOutput({tag, " err"}, 128'(err), 128'(exp_err));
        checkOutput({tag, " aes_cmd"}, 128'(aes_cmd), 128'(cmd));
        checkOutput({tag, " write count"}, 128'(wr_addrs.size()), 128'(exp_blk));
        for (int w = 0; w < wr_addrs.size() && w < exp_blk; w++) begin
            checkOutput($sformatf("%s addr%0d", tag, w), 128'(wr_addrs[w]), 128'(w));
            checkOutput($sformatf("%s data%0d", tag, w), wr_datas[w], packWord(beats, w));
        end
    endtask

    initial begin
        vec_t          vecs [8];
        logic [31:0]   bq [$];
        logic [31:0]   ecb_beats [8];
        int            n, words, blk;
        bit            e;

        ecb_beats = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f,
                      32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
        vecs[0] = '{"ecb",       ECB_ENCRYPT_128,  8,  0,  3, 1'b1, 2, 1'b0, 1'b1};
        vecs[1] = '{"cbc",       CBC_DECRYPT_128, 20, 30, 50, 1'b0, 5, 1'b0, 1'b1};
        vecs[2] = '{"partial",   ECB_ENCRYPT_128,  6,  0,  2, 1'b0, 2, 1'b1, 1'b1};
        vecs[3] = '{"overflow",  CBC_DECRYPT_128, 40, 20,  5, 1'b0, 8, 1'b1, 1'b1};
        vecs[4] = '{"cmd_only",  ECB_ENCRYPT_128,  0,  0,  0, 1'b0, 0, 1'b1, 1'b0};
        vecs[5] = '{"key_only",  ECB_ENCRYPT_128,  4,  0,  0, 1'b0, 1, 1'b1, 1'b0};
        vecs[6] = '{"one_beat",  CBC_DECRYPT_128,  1,  0,  0, 1'b0, 1, 1'b1, 1'b0};
        vecs[7] = '{"exact_full",ECB_ENCRYPT_128, 32, 10,  4, 1'b0, 8, 1'b0, 1'b1};

        $display("[TB] reset checks");
        repeat (3) @(negedge clk);
        checkOutput("reset tready", 128'(s_axis_tready), 128'(0));
        checkOutput("reset aes_cmd", 128'(aes_cmd), 128'(0));
        checkOutput("reset w_e", 128'(in_fifo_w_e), 128'(0));
        checkOutput("reset addr", 128'(in_fifo_addr), 128'(0));
        checkOutput("reset data", 128'(in_fifo_data), 128'(0));
        checkOutput("reset blk_cnt", 128'(in_fifo_blk_cnt), 128'(0));
        checkOutput("reset ctrl_en", 128'(ctrl_en), 128'(0));
        checkOutput("reset err", 128'(err), 128'(0));
        cycle();
        reset = 1'b0;
        cycle();

        $display("[TB] table vectors");
        for (int v = 0; v < 8; v++) begin
            bq.delete();
            for (int j = 0; j < vecs[v].nbeats; j++) begin
                bq.push_back(vecs[v].fixed_data ? ecb_beats[j] : $urandom());
            end
            applyStimulus(vecs[v].name, vecs[v].cmd, bq, vecs[v].gap_pct, vecs[v].done_delay,
                          vecs[v].exp_blk, vecs[v].exp_err, vecs[v].exp_start);
            if (v == 0) begin
                checkOutput("ecb addr0 word", wr_datas.size() > 0 ? wr_datas[0] : '0,
                            128'h00010203_04050607_08090a0b_0c0d0e0f);
            end
        end

        $display("[TB] random packets");
        for (int r = 0; r < 10; r++) begin
            n = $urandom_range(0, 40);
            bq.delete();
            for (int j = 0; j < n; j++) bq.push_back($urandom());
            words = (n + 3) / 4;
            blk = (words > CAP) ? CAP : words;
            e = (n == 0) || (n % 4 != 0) || (words > CAP) || (blk < 2);
            applyStimulus($sformatf("rand%0d", r), $urandom(), bq, $urandom_range(0, 40),
                          $urandom_range(1, 20), blk, e, blk >= 2);
        end

        $display("[TB] write latency sequence");
        wr_addrs.delete();
        wr_datas.delete();
        ctrl_en_seen = 0;
        sendBeat(ECB_ENCRYPT_128, 1'b0);
        for (int j = 0; j < 3; j++) sendBeat(32'h1000 + j, 1'b0);
        checkOutput("latency w_e before 4th", 128'(in_fifo_w_e), 128'(0));
        sendBeat(32'h1003, 1'b0);
        checkOutput("latency w_e after 4th", 128'(in_fifo_w_e), 128'(1));
        checkOutput("latency addr", 128'(in_fifo_addr), 128'(0));
        checkOutput("latency data", 128'(in_fifo_data), 128'h00001000_00001001_00001002_00001003);
        cycle();
        checkOutput("latency w_e pulse width", 128'(in_fifo_w_e), 128'(0));
        for (int j = 0; j < 4; j++) sendBeat(32'h2000 + j, j == 3);
        repeat (4) cycle();
        ctrl_done = 1'b1;
        cycle();
        ctrl_done = 1'b0;
        cycle();
        checkOutput("latency ctrl_en pulses", 128'(ctrl_en_seen), 128'(1));
        checkOutput("latency blk_cnt", 128'(in_fifo_blk_cnt), 128'(2));
`ifdef AES_PACKER_STATS_EN
        exp_pkts++;
`endif

        $display("[TB] mid-packet reset");
        wr_addrs.delete();
        wr_datas.delete();
        ctrl_en_seen = 0;
        sendBeat(CBC_DECRYPT_128, 1'b0);
        for (int j = 0; j < 3; j++) sendBeat($urandom(), 1'b0);
        reset = 1'b1;
        cycle();
        checkOutput("midreset tready", 128'(s_axis_tready), 128'(0));
        checkOutput("midreset aes_cmd", 128'(aes_cmd), 128'(0));
        reset = 1'b0;
        for (int k = 0; k < 5; k++) cycle();
        checkOutput("midreset writes", 128'(wr_addrs.size()), 128'(0));
        checkOutput("midreset ctrl_en", 128'(ctrl_en_seen), 128'(0));
        checkOutput("midreset err", 128'(err), 128'(0));
`ifdef AES_PACKER_STATS_EN
        exp_pkts = 0;
`endif
        bq.delete();
        for (int j = 0; j < 8; j++) bq.push_back(ecb_beats[j]);
        applyStimulus("after_reset", ECB_ENCRYPT_128, bq, 0, 2, 2, 1'b0, 1'b1);

`ifdef AES_PACKER_STATS_EN
        checkOutput("stats pkt_cnt", 128'(pkt_cnt), 128'(exp_pkts));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
